// File: rtl/pavana_scan_pkg.sv
// Shared types and helpers for the pavana serial scan I/O harness.
// Holds the unload state encoding and the counter-width helper.
package pavana_scan_pkg;

   localparam int unsigned DEF_IN_W  = 416;
   localparam int unsigned DEF_OUT_W = 400;

   typedef enum logic {
      IDLE   = 1'b0,
      UNLOAD = 1'b1
   } unload_state_e;

   // Counter width able to hold the value n itself.
   function automatic int unsigned cnt_w(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/pavana_scan_unload.sv
// Response capture and bit-serial unload: capture register, bit counter,
// IDLE/UNLOAD state machine and the valid/last flags.
module pavana_scan_unload
   import pavana_scan_pkg::*;
#(
   parameter int unsigned OUT_W    = DEF_OUT_W,
   parameter logic        FILL_BIT = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             rdcfg_i,
   input  logic [OUT_W-1:0] dut_out_i,
   output logic             shiftdata_o,
   output logic             out_valid_o,
   output logic             out_last_o
);

   localparam int unsigned   CW       = cnt_w(OUT_W);
   localparam logic [CW-1:0] CNT_FULL = CW'(OUT_W);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   unload_state_e    state_q, state_d;
   logic [OUT_W-1:0] out_sr_q, out_sr_d;
   logic [CW-1:0]    out_cnt_q, out_cnt_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         out_sr_q  <= '0;
         out_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         out_sr_q  <= out_sr_d;
         out_cnt_q <= out_cnt_d;
      end
   end

   // A capture request wins in either state, so a recapture simply restarts the stream.
   always_comb begin
      state_d   = state_q;
      out_sr_d  = out_sr_q;
      out_cnt_d = out_cnt_q;
      if (rdcfg_i) begin
         out_sr_d  = dut_out_i;
         out_cnt_d = CNT_FULL;
         state_d   = UNLOAD;
      end else begin
         case (state_q)
            UNLOAD: begin
               out_sr_d = {FILL_BIT, out_sr_q[OUT_W-1:1]};
               if (out_cnt_q != '0) out_cnt_d = out_cnt_q - CNT_ONE;
               if (out_cnt_q <= CNT_ONE) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign shiftdata_o = out_sr_q[0];
   assign out_valid_o = (out_cnt_q != '0);
   assign out_last_o  = (out_cnt_q == CNT_ONE);

endmodule

// File: rtl/pavana_scan_io_harness.sv
// Two-pin serial harness around a wide DUT: serial-in stimulus chain with
// optional shadow/update stage, and a serial-out response unload chain.
module pavana_scan_io_harness
   import pavana_scan_pkg::*;
#(
   parameter int unsigned IN_W      = DEF_IN_W,
   parameter int unsigned OUT_W     = DEF_OUT_W,
   parameter bit          SHADOW_EN = 1'b1,
   parameter logic        FILL_BIT  = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             shiftdata_i,
   input  logic             shift_en_i,
   input  logic             update_i,
   input  logic             rdcfg_i,
   input  logic [OUT_W-1:0] dut_out_i,
   output logic [IN_W-1:0]  dut_in_o,
   output logic             in_full_o,
   output logic             shiftdata_o,
   output logic             out_valid_o,
   output logic             out_last_o
);

   localparam int unsigned   CW     = cnt_w(IN_W);
   localparam logic [CW-1:0] IN_MAX = CW'(IN_W);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic [IN_W-1:0] in_sr_q;
   logic [CW-1:0]   in_cnt_q, in_cnt_d;
   logic            in_full_q;

   // An update coinciding with a shift counts that shift as the first of the next load.
   always_comb begin
      in_cnt_d = in_cnt_q;
      if (update_i)
         in_cnt_d = shift_en_i ? CNT_ONE : '0;
      else if (shift_en_i && (in_cnt_q != IN_MAX))
         in_cnt_d = in_cnt_q + CNT_ONE;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         in_sr_q   <= '0;
         in_cnt_q  <= '0;
         in_full_q <= 1'b0;
      end else begin
         if (shift_en_i) in_sr_q <= {in_sr_q[IN_W-2:0], shiftdata_i};
         in_cnt_q  <= in_cnt_d;
         in_full_q <= (in_cnt_d == IN_MAX);
      end
   end

   assign in_full_o = in_full_q;

   generate
      if (SHADOW_EN) begin : g_shadow
         logic [IN_W-1:0] shadow_q;
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i)         shadow_q <= '0;
            else if (update_i) shadow_q <= in_sr_q;
         end
         assign dut_in_o = shadow_q;
      end else begin : g_direct
         assign dut_in_o = in_sr_q;
      end
   endgenerate

   pavana_scan_unload #(
      .OUT_W    (OUT_W),
      .FILL_BIT (FILL_BIT)
   ) u_unload (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .rdcfg_i     (rdcfg_i),
      .dut_out_i   (dut_out_i),
      .shiftdata_o (shiftdata_o),
      .out_valid_o (out_valid_o),
      .out_last_o  (out_last_o)
   );

endmodule

// File: tb/tb_pavana_scan_io_harness.sv
// Directed self-checking bench for pavana_scan_io_harness at IN_W=OUT_W=8,
// with a shadowed instance and a direct (SHADOW_EN=0) instance on shared inputs.
module tb_pavana_scan_io_harness;

   logic       clk = 1'b0;
   logic       rst;
   logic       shiftdata, shift_en, update, rdcfg;
   logic [7:0] dut_out;
   logic [7:0] dut_in_s, dut_in_d;
   logic       full_s, full_d;
   logic       sdo_s, sdo_d, valid_s, valid_d, last_s, last_d;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pavana_scan_io_harness #(
      .IN_W(8), .OUT_W(8), .SHADOW_EN(1'b1), .FILL_BIT(1'b0)
   ) dut (
      .clk_i(clk), .rst_i(rst), .shiftdata_i(shiftdata), .shift_en_i(shift_en),
      .update_i(update), .rdcfg_i(rdcfg), .dut_out_i(dut_out), .dut_in_o(dut_in_s),
      .in_full_o(full_s), .shiftdata_o(sdo_s), .out_valid_o(valid_s), .out_last_o(last_s)
   );

   pavana_scan_io_harness #(
      .IN_W(8), .OUT_W(8), .SHADOW_EN(1'b0), .FILL_BIT(1'b0)
   ) dut0 (
      .clk_i(clk), .rst_i(rst), .shiftdata_i(shiftdata), .shift_en_i(shift_en),
      .update_i(update), .rdcfg_i(rdcfg), .dut_out_i(dut_out), .dut_in_o(dut_in_d),
      .in_full_o(full_d), .shiftdata_o(sdo_d), .out_valid_o(valid_d), .out_last_o(last_d)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic shift_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) begin
         shiftdata = v[i];
         shift_en  = 1'b1;
         tick();
      end
      shift_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; shiftdata = 1'b0; shift_en = 1'b0; update = 1'b0; rdcfg = 1'b0;
      dut_out = 8'h00;
      tick(); tick();
      rst = 1'b0;
      tick();
      total++; if (dut_in_s !== 8'h00) begin bad++; $display("FAIL reset_dut_in got=%h exp=00", dut_in_s); end
      total++; if (sdo_s !== 1'b0) begin bad++; $display("FAIL reset_sdo got=%b exp=0", sdo_s); end
      total++; if (valid_s !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_s); end
      total++; if (last_s !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", last_s); end
      total++; if (full_s !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full_s); end
   endtask

   task automatic test_shift_update();
      logic [7:0] pat;
      pat = 8'b1011_0010;
      for (int i = 7; i >= 0; i--) begin
         shiftdata = pat[i];
         shift_en  = 1'b1;
         tick();
         if (i == 1) begin
            total++; if (full_s !== 1'b0) begin bad++; $display("FAIL full_after7 got=%b exp=0", full_s); end
         end
      end
      shift_en = 1'b0;
      total++; if (full_s !== 1'b1) begin bad++; $display("FAIL full_after8 got=%b exp=1", full_s); end
      total++; if (dut_in_s !== 8'h00) begin bad++; $display("FAIL shadow_before_update got=%h exp=00", dut_in_s); end
      total++; if (dut_in_d !== 8'hB2) begin bad++; $display("FAIL direct_follows_sr got=%h exp=b2", dut_in_d); end
      // extra shift saturates the count but still moves data
      shiftdata = 1'b1; shift_en = 1'b1;
      tick();
      shift_en = 1'b0;
      total++; if (full_s !== 1'b1) begin bad++; $display("FAIL full_saturate got=%b exp=1", full_s); end
      total++; if (dut_in_d !== 8'h65) begin bad++; $display("FAIL extra_shift got=%h exp=65", dut_in_d); end
      update = 1'b1;
      tick();
      update = 1'b0;
      total++; if (dut_in_s !== 8'h65) begin bad++; $display("FAIL update_shadow got=%h exp=65", dut_in_s); end
      total++; if (full_s !== 1'b0) begin bad++; $display("FAIL update_clears_full got=%b exp=0", full_s); end
      total++; if (full_d !== 1'b0) begin bad++; $display("FAIL direct_update_clears_full got=%b exp=0", full_d); end
   endtask

   task automatic test_unload();
      logic [7:0] v;
      v = 8'hA5;
      dut_out = v; rdcfg = 1'b1;
      tick();
      rdcfg = 1'b0; dut_out = 8'h00;
      for (int k = 0; k < 8; k++) begin
         total++; if (sdo_s !== v[k]) begin bad++; $display("FAIL unload_bit%0d got=%b exp=%b", k, sdo_s, v[k]); end
         total++; if (valid_s !== 1'b1) begin bad++; $display("FAIL unload_valid%0d got=%b exp=1", k, valid_s); end
         total++; if (last_s !== (k == 7)) begin bad++; $display("FAIL unload_last%0d got=%b exp=%b", k, last_s, k == 7); end
         tick();
      end
      total++; if (sdo_s !== 1'b0) begin bad++; $display("FAIL unload_fill got=%b exp=0", sdo_s); end
      total++; if (valid_s !== 1'b0) begin bad++; $display("FAIL unload_done_valid got=%b exp=0", valid_s); end
      total++; if (last_s !== 1'b0) begin bad++; $display("FAIL unload_done_last got=%b exp=0", last_s); end
      tick();
      total++; if (valid_s !== 1'b0) begin bad++; $display("FAIL idle_hold_valid got=%b exp=0", valid_s); end
   endtask

   task automatic test_recapture();
      logic [7:0] v;
      dut_out = 8'hFF; rdcfg = 1'b1;
      tick();
      rdcfg = 1'b0;
      for (int k = 0; k < 3; k++) begin
         total++; if (sdo_s !== 1'b1) begin bad++; $display("FAIL pre_recap_bit%0d got=%b exp=1", k, sdo_s); end
         tick();
      end
      v = 8'h01;
      dut_out = v; rdcfg = 1'b1;
      tick();
      rdcfg = 1'b0;
      for (int k = 0; k < 8; k++) begin
         total++; if (sdo_s !== v[k]) begin bad++; $display("FAIL recap_bit%0d got=%b exp=%b", k, sdo_s, v[k]); end
         total++; if (valid_s !== 1'b1) begin bad++; $display("FAIL recap_valid%0d got=%b exp=1", k, valid_s); end
         total++; if (last_s !== (k == 7)) begin bad++; $display("FAIL recap_last%0d got=%b exp=%b", k, last_s, k == 7); end
         tick();
      end
      total++; if (valid_s !== 1'b0) begin bad++; $display("FAIL recap_done_valid got=%b exp=0", valid_s); end
   endtask

   task automatic test_shift_and_update();
      shift_byte(8'h3C);
      total++; if (dut_in_d !== 8'h3C) begin bad++; $display("FAIL preload_sr got=%h exp=3c", dut_in_d); end
      shiftdata = 1'b1; shift_en = 1'b1; update = 1'b1;
      tick();
      shift_en = 1'b0; update = 1'b0;
      total++; if (dut_in_s !== 8'h3C) begin bad++; $display("FAIL both_shadow got=%h exp=3c", dut_in_s); end
      total++; if (dut_in_d !== 8'h79) begin bad++; $display("FAIL both_sr got=%h exp=79", dut_in_d); end
      total++; if (dut.in_cnt_q !== 4'd1) begin bad++; $display("FAIL both_cnt got=%0d exp=1", dut.in_cnt_q); end
      total++; if (full_s !== 1'b0) begin bad++; $display("FAIL both_full got=%b exp=0", full_s); end
   endtask

   task automatic test_async_reset();
      dut_out = 8'hA5; rdcfg = 1'b1;
      tick();
      rdcfg = 1'b0;
      shiftdata = 1'b1; shift_en = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      total++; if (valid_s !== 1'b1) begin bad++; $display("FAIL mid_unload_valid got=%b exp=1", valid_s); end
      total++; if (dut_in_d === 8'h00) begin bad++; $display("FAIL mid_shift_nonzero got=%h exp=nonzero", dut_in_d); end
      #2;
      rst = 1'b1;
      #1;
      total++; if (dut_in_s !== 8'h00) begin bad++; $display("FAIL arst_dut_in got=%h exp=00", dut_in_s); end
      total++; if (dut_in_d !== 8'h00) begin bad++; $display("FAIL arst_direct_dut_in got=%h exp=00", dut_in_d); end
      total++; if (sdo_s !== 1'b0) begin bad++; $display("FAIL arst_sdo got=%b exp=0", sdo_s); end
      total++; if (valid_s !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", valid_s); end
      total++; if (last_s !== 1'b0) begin bad++; $display("FAIL arst_last got=%b exp=0", last_s); end
      total++; if (full_d !== 1'b0) begin bad++; $display("FAIL arst_full got=%b exp=0", full_d); end
      shift_en = 1'b0;
      tick();
      rst = 1'b0;
      tick(); tick();
      total++; if (valid_s !== 1'b0) begin bad++; $display("FAIL no_resume_valid got=%b exp=0", valid_s); end
      total++; if (sdo_s !== 1'b0) begin bad++; $display("FAIL no_resume_sdo got=%b exp=0", sdo_s); end
      total++; if (dut.in_cnt_q !== 4'd0) begin bad++; $display("FAIL no_resume_cnt got=%0d exp=0", dut.in_cnt_q); end
   endtask

   initial begin
      test_reset();
      test_shift_update();
      test_unload();
      test_recapture();
      test_shift_and_update();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pavana_scan_io_harness.md
Name: pavana_scan_io_harness

Overview:
- Parametrised serial test/synthesis harness that lets a wide DUT sit behind a two-pin serial interface.
- Serial-in chain loads a shadowed stimulus vector that drives the DUT inputs.
- Serial-out chain captures the DUT outputs on request and unloads them bit-serially, with count, valid and last flags.
- Sits between the pad-limited top level and any pavana_xbar variant; generalises the fixed-width wrapper. Adds a shadow/update stage, gated shift, bit counters and an unload state machine.

Parameters:
- IN_W, 416, stimulus vector width (bits driven into DUT); minimum 2.
- OUT_W, 400, response vector width (bits sampled from DUT); minimum 2.
- SHADOW_EN, 1, 1: dut_in_o changes only on update_i; 0: dut_in_o follows the shift register directly.
- FILL_BIT, 1'b0, value shifted into the MSB of the unload register.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- shiftdata_i  in  1  serial stimulus bit
- shift_en_i  in  1  shift stimulus chain this cycle
- update_i  in  1  transfer stimulus chain to shadow
- rdcfg_i  in  1  capture DUT response and start unload
- dut_out_i  in  OUT_W  DUT response vector
- dut_in_o  out  IN_W  DUT stimulus vector
- in_full_o  out  1  IN_W bits shifted since last update/reset
- shiftdata_o  out  1  serial response bit (LSB of unload register)
- out_valid_o  out  1  shiftdata_o holds a valid captured bit
- out_last_o  out  1  shiftdata_o is the final (MSB) captured bit

Behaviour:
- Async reset values: stimulus shift register 0, shadow 0 (dut_in_o=0), in_cnt 0, in_full_o 0, unload register 0 (shiftdata_o=0), out_cnt 0, out_valid_o 0, out_last_o 0, FSM in IDLE.
- Stimulus chain, when shift_en_i=1: in_sr <= {in_sr[IN_W-2:0], shiftdata_i}. The first bit shifted ends at MSB after IN_W shifts.
- in_cnt increments per shift and saturates at IN_W. in_full_o = (in_cnt==IN_W), registered. Extra shifts still move data.
- update_i=1 (SHADOW_EN=1): shadow <= in_sr and in_cnt <= 0. dut_in_o changes in the cycle after the update edge.
- If shift_en_i and update_i are both high: the shadow takes the pre-shift in_sr, the shift occurs, and in_cnt <= 1.
- SHADOW_EN=0: dut_in_o = in_sr, and update_i only clears in_cnt.
- Unload FSM has two states, IDLE and UNLOAD.
  - rdcfg_i=1 in any state: out_sr <= dut_out_i, out_cnt <= OUT_W, state <= UNLOAD. Recapture mid-unload aborts the current unload with no error.
  - UNLOAD with rdcfg_i=0: out_sr <= {FILL_BIT, out_sr[OUT_W-1:1]} and out_cnt--. On out_cnt 1->0, state <= IDLE.
  - IDLE with rdcfg_i=0: out_sr holds.
- out_valid_o = (out_cnt != 0); out_last_o = (out_cnt == 1). Both derive from registered state, with no combinational path from inputs.
- Latency: capture at edge N; dut_out_i[0] appears on shiftdata_o in cycle N+1; bit k appears in cycle N+1+k; out_last_o is high in cycle N+OUT_W.
- Counters are $clog2(IN_W+1) and $clog2(OUT_W+1) bits wide and never wrap.
- Both chains are independent and may operate simultaneously.
- Reset asserted mid-shift or mid-unload returns everything to reset values immediately. No partial state survives.

Decomposition:
- Package pavana_scan_pkg holds:
  - unload state enum (IDLE, UNLOAD);
  - function cnt_w(n) = $clog2(n+1);
  - default-width localparams.
- Sub-module pavana_scan_unload (capture register, out_cnt, FSM, valid/last flags).
- The stimulus chain and shadow stay in the top module.

Test Plan (IN_W=8, OUT_W=8 unless noted):
- Reset then idle: dut_in_o=8'h00, shiftdata_o=0, out_valid_o=0, in_full_o=0.
- Shift 1,0,1,1,0,0,1,0 with shift_en_i=1 -> in_full_o=1 after 8th edge and dut_in_o still 00. Pulse update_i -> dut_in_o=8'hB2 next cycle and in_full_o=0.
- dut_out_i=8'hA5, pulse rdcfg_i -> shiftdata_o sequence 1,0,1,0,0,1,0,1 over 8 cycles. out_valid_o high 8 cycles; out_last_o high only on 8th; then shiftdata_o=FILL_BIT and valid=0.
- Recapture: rdcfg_i with 8'hFF, then rdcfg_i again after 3 bits with dut_out_i=8'h01 -> stream restarts with 1,0,0,0,0,0,0,0 and a full 8-bit valid window.
- Simultaneous shift_en_i and update_i with in_sr=8'h3C, shiftdata_i=1 -> dut_in_o=8'h3C, in_sr=8'h79, in_cnt=1.
- Async reset asserted in mid-unload (bit 4) and mid-shift (SHADOW_EN=0) -> all outputs return to reset values without a clock edge. The unload does not resume after reset release.
